// File: rtl/mux_result_deserializer.sv
// Packs one result bit per accepted mux beat (in_and | in_or) into a WIDTH-bit word, LSB first.
// Optional MUX_ONEHOT_CHECK_EN builds a sticky flag for beats with both mux outputs high.
module mux_result_deserializer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  logic                         in_and_i,
   input  logic                         in_or_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic [WIDTH-1:0]             out_data_o,
   output logic [$clog2(WIDTH+1)-1:0]   bit_count_o,
   output logic                         err_o
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   typedef enum logic [0:0] {StCollect, StFull} state_e;

   state_e             state_q, state_d;
   logic [CntW-1:0]    count_q, count_d;
   logic [WIDTH-1:0]   sr_q, sr_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic [WIDTH-1:0]   sr_shift;
   logic               accept;

   assign in_ready_o  = (state_q == StCollect);
   assign out_valid_o = (state_q == StFull);
   assign out_data_o  = data_q;
   assign bit_count_o = count_q;
   assign accept      = in_valid_i & in_ready_o;
   assign sr_shift    = {in_and_i | in_or_i, sr_q[WIDTH-1:1]};

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      sr_d    = sr_q;
      data_d  = data_q;
      unique case (state_q)
         StCollect: begin
            if (in_valid_i) begin
               sr_d = sr_shift;
               if (count_q == LastCnt) begin
                  data_d  = sr_shift;
                  count_d = '0;
                  state_d = StFull;
               end else begin
                  count_d = count_q + CntW'(1);
               end
            end
         end
         StFull: begin
            // No beat is taken while the word is handed over.
            if (out_ready_i) state_d = StCollect;
         end
         default: state_d = StCollect;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StCollect;
         count_q <= '0;
         sr_q    <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         sr_q    <= sr_d;
         data_q  <= data_d;
      end
   end

`ifdef MUX_ONEHOT_CHECK_EN
   logic err_q, err_d;

   assign err_d = err_q | (accept & in_and_i & in_or_i);
   assign err_o = err_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) err_q <= 1'b0;
      else         err_q <= err_d;
   end
`else
   logic unused_accept;

   assign unused_accept = accept;
   assign err_o         = 1'b0;
`endif

endmodule

// File: tb/tb_mux_result_deserializer.sv
// Directed, table-driven bench for mux_result_deserializer (WIDTH=8).
module tb_mux_result_deserializer;

   localparam int unsigned W = 8;

`ifdef MUX_ONEHOT_CHECK_EN
   localparam logic ErrExp = 1'b1;
`else
   localparam logic ErrExp = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_and, in_or, out_ready;
   logic         in_ready, out_valid, err;
   logic [W-1:0] out_data;
   logic [3:0]   bit_count;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic       v;
      logic       a;
      logic       o;
      logic       rdy;
      logic       e_ir;
      logic       e_ov;
      logic [7:0] e_data;
      logic [3:0] e_cnt;
      string      name;
   } vec_t;

   vec_t tbl[$];

   mux_result_deserializer #(.WIDTH(W)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_and_i    (in_and),
      .in_or_i     (in_or),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_data),
      .bit_count_o (bit_count),
      .err_o       (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void add(input logic v, input logic a, input logic o, input logic rdy,
                               input logic e_ir, input logic e_ov, input logic [7:0] e_data,
                               input logic [3:0] e_cnt, input string name);
      vec_t x;
      x.v = v; x.a = a; x.o = o; x.rdy = rdy;
      x.e_ir = e_ir; x.e_ov = e_ov; x.e_data = e_data; x.e_cnt = e_cnt; x.name = name;
      tbl.push_back(x);
   endfunction

   task automatic step(input logic v, input logic a, input logic o, input logic rdy);
      in_valid  = v;
      in_and    = a;
      in_or     = o;
      out_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string name, input logic e_ir, input logic e_ov,
                            input logic [7:0] e_data, input logic [3:0] e_cnt);
      chk({name, ".in_ready"}, 32'(in_ready), 32'(e_ir));
      chk({name, ".out_valid"}, 32'(out_valid), 32'(e_ov));
      chk({name, ".out_data"}, 32'(out_data), 32'(e_data));
      chk({name, ".bit_count"}, 32'(bit_count), 32'(e_cnt));
   endtask

   // Asserts reset mid-cycle, checks the async clear, releases on the falling edge.
   task automatic reset_pulse(input string name);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk({name, ".rst_valid"}, 32'(out_valid), 32'd0);
      chk({name, ".rst_data"}, 32'(out_data), 32'd0);
      chk({name, ".rst_count"}, 32'(bit_count), 32'd0);
      chk({name, ".rst_err"}, 32'(err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk({name, ".rel_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic [7:0] w4d;
      logic [7:0] wa5;
      logic       b;
      w4d = 8'h4D;
      wa5 = 8'hA5;

      // Basic word, back to back.
      for (int i = 0; i < 8; i++) begin
         b = w4d[i];
         add(1'b1, b, 1'b0, 1'b0, i != 7, i == 7, (i == 7) ? w4d : 8'h00, 4'((i + 1) % 8),
             $sformatf("basic%0d", i));
      end
      // Backpressure: beats in FULL are ignored.
      for (int i = 0; i < 5; i++)
         add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, w4d, 4'd0, $sformatf("bp%0d", i));
      add(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, w4d, 4'd0, "bp_release");
      // Gapped input, mux outputs toggling while idle, alternating AND/OR path.
      for (int i = 0; i < 8; i++) begin
         b = w4d[i];
         add(1'b0, i[0], ~i[0], 1'b0, 1'b1, 1'b0, w4d, 4'(i), $sformatf("gap_idle%0d", i));
         add(1'b1, i[0] ? 1'b0 : b, i[0] ? b : 1'b0, 1'b0, i != 7, i == 7, w4d,
             4'((i + 1) % 8), $sformatf("gap_beat%0d", i));
      end
      add(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, w4d, 4'd0, "gap_release");
      // Second word with out_ready held high throughout; bubble then first beat of next word.
      for (int i = 0; i < 8; i++) begin
         b = wa5[i];
         add(1'b1, 1'b0, b, 1'b1, i != 7, i == 7, (i == 7) ? wa5 : w4d, 4'((i + 1) % 8),
             $sformatf("a5_%0d", i));
      end
      add(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, wa5, 4'd0, "bubble");
      add(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, wa5, 4'd1, "after_bubble");

      rst_n     = 1'b1;
      in_valid  = 1'b0;
      in_and    = 1'b0;
      in_or     = 1'b0;
      out_ready = 1'b0;
      @(posedge clk);
      reset_pulse("init");

      foreach (tbl[k]) begin
         step(tbl[k].v, tbl[k].a, tbl[k].o, tbl[k].rdy);
         check_all(tbl[k].name, tbl[k].e_ir, tbl[k].e_ov, tbl[k].e_data, tbl[k].e_cnt);
         chk({tbl[k].name, ".err"}, 32'(err), 32'd0);
      end

      // Reset mid-word discards the partial count.
      reset_pulse("mid_a");
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
      check_all("three_ones", 1'b1, 1'b0, 8'h00, 4'd3);
      reset_pulse("mid_b");
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
      check_all("zeros_word", 1'b0, 1'b1, 8'h00, 4'd0);

      // Build a nonzero word, then reset while FULL.
      step(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b1, i[1], 1'b0, 1'b0);
      check_all("cc_word", 1'b0, 1'b1, 8'hCC, 4'd0);
      reset_pulse("full_rst");

      // One-hot violation: bit is still 1, flag sticky across the next word.
      step(1'b1, 1'b1, 1'b1, 1'b0);
      chk("onehot.err", 32'(err), 32'(ErrExp));
      for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
      check_all("onehot_word", 1'b0, 1'b1, 8'h01, 4'd0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
      check_all("ff_word", 1'b0, 1'b1, 8'hFF, 4'd0);
      chk("onehot.sticky", 32'(err), 32'(ErrExp));
      reset_pulse("err_clear");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
